// File: rtl/imem_pkg.sv
// Shared types, constants and the address-legality helper for the
// instruction-memory responder.
package imem_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INS_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

  // True when a byte address is misaligned or falls outside the mapped window.
  function automatic logic addr_bad(input logic [XLEN-1:0] addr,
                                    input logic [XLEN-1:0] base,
                                    input logic [XLEN-1:0] depth);
    logic [XLEN-1:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one write port, one registered read port.
// Contents are loaded through the write port; only the read register resets.
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Reading the pre-edge array value gives old data on a same-word write.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fetch FSM, wait-state counter, PC checks.
// Define IMEM_STATS_EN to add saturating fetch_count/err_count outputs.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_ins,
  output logic [31:0] rsp_pc,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] err_count
`endif
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [XLEN-1:0] DEPTH_W   = XLEN'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_CYCLES);

  imem_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic            rdy_q, rdy_d;

  logic [XLEN-1:0] fetch_pc;
  logic            fetch_bad;
  logic            enter_resp;
  logic            rd_en;
  logic [AW-1:0]   rd_idx;
  logic            wr_ok;
  logic [AW-1:0]   wr_idx;
  logic [31:0]     rd_data;

  // With zero wait states the read happens on the accept edge, so use req_pc.
  assign fetch_pc  = (state_q == IDLE) ? req_pc : pc_q;
  assign fetch_bad = addr_bad(fetch_pc, BASE_ADDR, DEPTH_W);
  assign rd_idx    = AW'((fetch_pc - BASE_ADDR) >> 2);
  assign wr_ok     = wr_en && !addr_bad(wr_addr, BASE_ADDR, DEPTH_W);
  assign wr_idx    = AW'((wr_addr - BASE_ADDR) >> 2);
  assign rd_en     = enter_resp && !fetch_bad;
  assign rdy_d     = 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          pc_d  = req_pc;
          cnt_d = WAIT_LOAD;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A redirect beats everything, including an accept in the same cycle.
    if (flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      enter_resp = 1'b0;
    end
    if (enter_resp) err_d = fetch_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign req_ready = rdy_q && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_pc    = pc_q;
  assign rsp_err   = err_q;
  assign rsp_ins   = err_q ? INS_NOP : rd_data;

`ifdef IMEM_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (rsp_valid && rsp_ready) begin
      if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (err_q && (err_cnt_q != 32'hFFFF_FFFF)) err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign err_count   = err_cnt_q;
`endif

endmodule
